// File: rtl/rr_mux_pkg.sv
// Shared defaults, mode encodings and index-width helper for the round-robin mux arbiter.
package rr_mux_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_N     = 4;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Channel-index width; never below one bit so N=2 still has a usable select.
  function automatic int calc_selw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_mux_arbiter_if.sv
// Handshake bundle between N upstream channels, the arbiter and one downstream sink.
interface rr_mux_arbiter_if
  import rr_mux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N     = DEF_N
);
  localparam int SELW = calc_selw(N);

  logic                 mode;
  logic [SELW-1:0]      sel;
  logic [N*WIDTH-1:0]   in_data;
  logic [N-1:0]         in_valid;
  logic [N-1:0]         in_ready;
  logic [WIDTH-1:0]     out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [SELW-1:0]      grant;

  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, grant
  );

  modport slave (
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, grant
  );

endinterface

// File: rtl/rr_priority_picker.sv
// Rotated-priority search: first set req bit starting at ptr and wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the pick is consumed.
module rr_priority_picker
  import rr_mux_pkg::*;
#(
  parameter int N    = DEF_N,
  parameter int SELW = calc_selw(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic            found,
  output logic [SELW-1:0] idx
);

  // Scan from farthest to nearest so the candidate closest to ptr wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        found = 1'b1;
        idx   = SELW'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// N-to-1 registered mux with fixed-select or round-robin channel choice.
// Latency: 1 cycle from upstream transfer to out_valid.
// Backpressure: single output register; refills in the same cycle it drains, stalls all inputs otherwise.
module rr_mux_arbiter
  import rr_mux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N     = DEF_N
) (
  input  logic              clk,
  input  logic              rst_n,
  rr_mux_arbiter_if.slave   bus
);

  localparam int SELW = calc_selw(N);

  logic [WIDTH-1:0] out_data_q;
  logic             out_valid_q;
  logic [SELW-1:0]  grant_q;
  logic [SELW-1:0]  ptr_q;

  logic             rr_found;
  logic [SELW-1:0]  rr_idx;
  logic             fix_found;
  logic             found;
  logic [SELW-1:0]  idx;
  logic             load_en;
  logic             take;

  rr_priority_picker #(
    .N    (N),
    .SELW (SELW)
  ) u_picker (
    .req   (bus.in_valid),
    .ptr   (ptr_q),
    .found (rr_found),
    .idx   (rr_idx)
  );

  // Out-of-range select must not index past the valid vector.
  assign fix_found = (int'(bus.sel) < N) ? bus.in_valid[bus.sel] : 1'b0;

  assign found   = (bus.mode == MODE_RR) ? rr_found : fix_found;
  assign idx     = (bus.mode == MODE_RR) ? rr_idx   : bus.sel;
  assign load_en = !out_valid_q | bus.out_ready;
  assign take    = load_en & found & rst_n;

  assign bus.in_ready  = take ? (N'(1) << idx) : '0;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.grant     = grant_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      grant_q     <= '0;
      ptr_q       <= '0;
    end else if (load_en) begin
      if (found) begin
        out_data_q  <= bus.in_data[int'(idx) * WIDTH +: WIDTH];
        out_valid_q <= 1'b1;
        grant_q     <= idx;
        ptr_q       <= (idx == SELW'(N - 1)) ? '0 : idx + 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter: a cycle table on an N=4 instance plus reset and N=3 sequences.
module tb_rr_mux_arbiter;

  logic clk;
  logic rst_n;

  rr_mux_arbiter_if #(.WIDTH(4), .N(4)) bus4 ();
  rr_mux_arbiter_if #(.WIDTH(4), .N(3)) bus3 ();

  rr_mux_arbiter #(.WIDTH(4), .N(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
  rr_mux_arbiter #(.WIDTH(4), .N(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  iv;
    logic [15:0] dat;
    logic        ordy;
    logic [3:0]  exp_ir;
    logic        exp_ov;
    logic [3:0]  exp_od;
    logic [1:0]  exp_g;
  } vec_t;

  vec_t vecs[16];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // mode sel iv dat ordy | in_ready out_valid out_data grant
    vecs[0]  = '{1'b1, 2'd0, 4'b1111, 16'h4321, 1'b1, 4'b0001, 1'b1, 4'h1, 2'd0};
    vecs[1]  = '{1'b1, 2'd0, 4'b1111, 16'h4321, 1'b1, 4'b0010, 1'b1, 4'h2, 2'd1};
    vecs[2]  = '{1'b1, 2'd0, 4'b1111, 16'h4321, 1'b1, 4'b0100, 1'b1, 4'h3, 2'd2};
    vecs[3]  = '{1'b1, 2'd0, 4'b1111, 16'h4321, 1'b1, 4'b1000, 1'b1, 4'h4, 2'd3};
    vecs[4]  = '{1'b1, 2'd0, 4'b1111, 16'h4321, 1'b1, 4'b0001, 1'b1, 4'h1, 2'd0};
    vecs[5]  = '{1'b1, 2'd0, 4'b1111, 16'h8765, 1'b0, 4'b0000, 1'b1, 4'h1, 2'd0};
    vecs[6]  = '{1'b1, 2'd0, 4'b1111, 16'h8765, 1'b0, 4'b0000, 1'b1, 4'h1, 2'd0};
    vecs[7]  = '{1'b1, 2'd0, 4'b1111, 16'h8765, 1'b0, 4'b0000, 1'b1, 4'h1, 2'd0};
    vecs[8]  = '{1'b1, 2'd0, 4'b1111, 16'h4321, 1'b1, 4'b0010, 1'b1, 4'h2, 2'd1};
    vecs[9]  = '{1'b0, 2'd2, 4'b0100, 16'h0A00, 1'b1, 4'b0100, 1'b1, 4'hA, 2'd2};
    vecs[10] = '{1'b1, 2'd0, 4'b0010, 16'h4321, 1'b1, 4'b0010, 1'b1, 4'h2, 2'd1};
    vecs[11] = '{1'b1, 2'd0, 4'b0000, 16'h4321, 1'b1, 4'b0000, 1'b0, 4'h2, 2'd1};
    vecs[12] = '{1'b0, 2'd3, 4'b1111, 16'h4321, 1'b0, 4'b1000, 1'b1, 4'h4, 2'd3};
    vecs[13] = '{1'b1, 2'd0, 4'b1111, 16'h9999, 1'b0, 4'b0000, 1'b1, 4'h4, 2'd3};
    vecs[14] = '{1'b1, 2'd0, 4'b0110, 16'h4321, 1'b1, 4'b0010, 1'b1, 4'h2, 2'd1};
    vecs[15] = '{1'b0, 2'd0, 4'b0110, 16'h4321, 1'b1, 4'b0000, 1'b0, 4'h2, 2'd1};

    // Reset with requests pending: everything must read zero.
    rst_n = 1'b0;
    bus4.mode = 1'b1; bus4.sel = 2'd0; bus4.in_valid = 4'b1111;
    bus4.in_data = 16'h4321; bus4.out_ready = 1'b1;
    bus3.mode = 1'b1; bus3.sel = 2'd0; bus3.in_valid = 3'b111;
    bus3.in_data = 12'h765; bus3.out_ready = 1'b1;
    #1;
    check("rst_ir",  32'(bus4.in_ready),  32'h0);
    check("rst_ov",  32'(bus4.out_valid), 32'h0);
    check("rst_od",  32'(bus4.out_data),  32'h0);
    check("rst_g",   32'(bus4.grant),     32'h0);
    check("rst3_ir", 32'(bus3.in_ready),  32'h0);
    @(posedge clk); #1;
    check("rst_ov_hold", 32'(bus4.out_valid), 32'h0);

    @(negedge clk);
    bus4.in_valid = 4'b0000;
    bus3.in_valid = 3'b000;
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus4.mode      = vecs[i].mode;
      bus4.sel       = vecs[i].sel;
      bus4.in_valid  = vecs[i].iv;
      bus4.in_data   = vecs[i].dat;
      bus4.out_ready = vecs[i].ordy;
      #1;
      check($sformatf("v%0d_ir", i), 32'(bus4.in_ready), 32'(vecs[i].exp_ir));
      @(posedge clk); #1;
      check($sformatf("v%0d_ov", i), 32'(bus4.out_valid), 32'(vecs[i].exp_ov));
      check($sformatf("v%0d_od", i), 32'(bus4.out_data),  32'(vecs[i].exp_od));
      check($sformatf("v%0d_g",  i), 32'(bus4.grant),     32'(vecs[i].exp_g));
    end

    // Load channel 3 and hold it, then reset asynchronously mid-cycle.
    @(negedge clk);
    bus4.mode = 1'b0; bus4.sel = 2'd3; bus4.in_valid = 4'b1111;
    bus4.in_data = 16'h4321; bus4.out_ready = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_ov", 32'(bus4.out_valid), 32'h1);
    check("pre_rst_g",  32'(bus4.grant),     32'h3);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ov", 32'(bus4.out_valid), 32'h0);
    check("arst_od", 32'(bus4.out_data),  32'h0);
    check("arst_g",  32'(bus4.grant),     32'h0);
    check("arst_ir", 32'(bus4.in_ready),  32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus4.mode = 1'b1; bus4.out_ready = 1'b1;
    #1;
    check("post_rst_ir", 32'(bus4.in_ready), 32'h1);
    @(posedge clk); #1;
    check("post_rst_g",  32'(bus4.grant),     32'h0);
    check("post_rst_od", 32'(bus4.out_data),  32'h1);
    check("post_rst_ov", 32'(bus4.out_valid), 32'h1);
    @(negedge clk);
    bus4.in_valid = 4'b0000;

    // N=3: select index 3 is out of range, so the held word drains and nothing refills.
    bus3.mode = 1'b0; bus3.sel = 2'd2; bus3.in_valid = 3'b111; bus3.out_ready = 1'b0;
    #1;
    check("n3_ld_ir", 32'(bus3.in_ready), 32'h4);
    @(posedge clk); #1;
    check("n3_ld_od", 32'(bus3.out_data),  32'h7);
    check("n3_ld_g",  32'(bus3.grant),     32'h2);
    @(negedge clk);
    bus3.sel = 2'd3;
    #1;
    check("n3_hold_ir", 32'(bus3.in_ready), 32'h0);
    @(posedge clk); #1;
    check("n3_hold_ov", 32'(bus3.out_valid), 32'h1);
    @(negedge clk);
    bus3.out_ready = 1'b1;
    #1;
    check("n3_oob_ir", 32'(bus3.in_ready), 32'h0);
    @(posedge clk); #1;
    check("n3_drain_ov", 32'(bus3.out_valid), 32'h0);
    check("n3_drain_od", 32'(bus3.out_data),  32'h7);
    check("n3_drain_g",  32'(bus3.grant),     32'h2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
